// File: rtl/swan_pkg.sv
// Shared constants and state encoding for the SWAN256 serial key schedule.
// Anything that must agree between the schedule stages lives here.
package swan_pkg;

    localparam int BLOCK_SIZE = 256;
    localparam int SIDE_SIZE  = BLOCK_SIZE / 2;
    localparam int KEY_SIZE   = 512;
    localparam int ROUNDS     = 64;
    localparam int KR         = 3;
    localparam int CNT_W      = $clog2(ROUNDS);
    localparam int RC_W       = 8;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/key_seg_update.sv
// Retiring-segment transform: rotate toward index 0 by ROT, then XOR the
// round constant into the low-order (highest-index) bits. Purely combinational.
module key_seg_update #(
    parameter int W       = 128,
    parameter int ROT     = 3,
    parameter int RC_BITS = 8
) (
    input  logic [0:W-1]         i_seg,
    input  logic [RC_BITS-1:0]   i_rc,
    output logic [0:W-1]         o_seg
);

    localparam int R = ROT % W;

    logic [0:W-1] w_rot;

    generate
        if (R == 0) begin : g_no_rot
            assign w_rot = i_seg;
        end else begin : g_rot
            // Bits at indices R.. move to the head; the first R bits wrap to the tail.
            assign w_rot = {i_seg[R:W-1], i_seg[0:R-1]};
        end
    endgenerate

    assign o_seg = w_rot ^ {{(W - RC_BITS){1'b0}}, i_rc};

endmodule

// File: rtl/serial_round_key_gen.sv
// Serial SWAN256 key schedule: emits one SIDE_SIZE-bit round key per accepted
// handshake from a shifting KEY_SIZE-bit key register, ROUNDS keys per load.
module serial_round_key_gen
    import swan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:KEY_SIZE-1]  key_in,
    output logic [0:SIDE_SIZE-1] rk,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [CNT_W-1:0]     rk_round,
    output logic                 busy,
    output logic                 done,
    output state_t               dbg_state
);

    // Handshake: a round key transfers on a rising edge where rk_valid && rk_ready.
    // rk_valid comes only from registered state, never from rk_ready; while
    // rk_ready is low, rk and rk_round hold for as long as the stall lasts.

    state_t               r_state;
    state_t               w_state_nxt;
    logic [0:KEY_SIZE-1]  r_key;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W:0]       w_cnt_inc;
    logic [RC_W-1:0]      w_rc;
    logic [0:SIDE_SIZE-1] w_seg_new;
    logic                 w_load;
    logic                 w_advance;
    logic                 w_last;

    // One extra bit on the increment so cnt+1 never wraps before it feeds rc.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_rc      = RC_W'(w_cnt_inc);
    assign w_load    = (r_state == IDLE) && start;
    assign w_advance = (r_state == RUN) && rk_ready;
    assign w_last    = (r_cnt == LAST_CNT);

    key_seg_update #(
        .W       (SIDE_SIZE),
        .ROT     (KR),
        .RC_BITS (RC_W)
    ) u_seg_update (
        .i_seg (r_key[0:SIDE_SIZE-1]),
        .i_rc  (w_rc),
        .o_seg (w_seg_new)
    );

    always_comb begin
        w_state_nxt = r_state;
        rk_valid    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_key <= key_in;
            r_cnt <= '0;
        end else if (w_advance) begin
            // Retire the head segment to the tail after transforming it.
            r_key <= {r_key[SIDE_SIZE:KEY_SIZE-1], w_seg_new};
            if (!w_last) begin
                r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    assign rk        = r_key[0:SIDE_SIZE-1];
    assign rk_round  = r_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_round_key_gen.sv
// Scoreboard bench for serial_round_key_gen: a segment-queue reference model
// predicts every round key; a monitor pops and compares on each transfer.
module tb_serial_round_key_gen;
    import swan_pkg::*;

    logic                 clk      = 1'b0;
    logic                 rst      = 1'b1;
    logic                 start    = 1'b0;
    logic                 rk_ready = 1'b0;
    logic [0:KEY_SIZE-1]  key_in   = '0;
    logic [0:SIDE_SIZE-1] rk;
    logic                 rk_valid;
    logic [CNT_W-1:0]     rk_round;
    logic                 busy;
    logic                 done;
    state_t               dbg_state;

    serial_round_key_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk        (rk),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    logic [SIDE_SIZE-1:0] exp_q[$];
    int                   exp_round_q[$];
    logic [SIDE_SIZE-1:0] obs_rk [ROUNDS];

    logic ready_manual = 1'b0;
    logic ready_val    = 1'b1;
    logic ready_rand   = 1'b0;

    task automatic check(input string name, input logic [SIDE_SIZE-1:0] act,
                         input logic [SIDE_SIZE-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the key is a queue of numeric segments; each round
    // emits the head, then appends rotl(head, KR) xor (round + 1).
    function automatic logic [SIDE_SIZE-1:0] rotl(input logic [SIDE_SIZE-1:0] s, input int k);
        return (s << k) | (s >> (SIDE_SIZE - k));
    endfunction

    task automatic model_push(input logic [0:KEY_SIZE-1] key);
        logic [SIDE_SIZE-1:0] segs[$];
        logic [SIDE_SIZE-1:0] s;
        for (int i = 0; i < KEY_SIZE / SIDE_SIZE; i++) segs.push_back(key[i*SIDE_SIZE +: SIDE_SIZE]);
        for (int r = 0; r < ROUNDS; r++) begin
            exp_q.push_back(segs[0]);
            exp_round_q.push_back(r);
            s = segs.pop_front();
            segs.push_back(rotl(s, KR) ^ SIDE_SIZE'(r + 1));
        end
    endtask

    function automatic logic [0:KEY_SIZE-1] rand_key();
        logic [0:KEY_SIZE-1] k;
        for (int j = 0; j < KEY_SIZE / 32; j++) k[j*32 +: 32] = $urandom();
        return k;
    endfunction

    // Ready driver: changes rk_ready just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_manual) rk_ready = ready_val;
            else if (ready_rand) rk_ready = ($urandom_range(0, 3) != 0);
            else rk_ready = 1'b1;
        end
    end

    // Monitor: samples on the falling edge, between input changes and the next capture edge.
    logic                 prev_stall = 1'b0;
    logic [SIDE_SIZE-1:0] prev_rk    = '0;
    int                   prev_round = 0;
    logic [SIDE_SIZE-1:0] mon_e;
    int                   mon_er;

    always @(negedge clk) begin
        if (rk_valid) begin
            if (prev_stall) begin
                check("stall_hold_rk", rk, prev_rk);
                check("stall_hold_round", rk_round, prev_round);
            end
            if (rk_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rk: round %0d presented, expected queue empty", rk_round);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_er = exp_round_q.pop_front();
                    check("rk_round", rk_round, mon_er);
                    check("rk_value", rk, mon_e);
                    obs_rk[rk_round] = rk;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_rk    = rk;
                prev_round = rk_round;
            end
        end else begin
            prev_stall = 1'b0;
        end
        if (done) begin
            done_seen++;
            check("done_queue_empty", exp_q.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sched(input logic [0:KEY_SIZE-1] key);
        key_in = key;
        start  = 1'b1;
        model_push(key);
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", max_cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rk"}, rk, 0);
        check({tag, "_rk_valid"}, rk_valid, 0);
        check({tag, "_rk_round"}, rk_round, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [SIDE_SIZE-1:0] top_bit;
        logic [SIDE_SIZE-1:0] hold_rk;
        logic [0:KEY_SIZE-1]  k;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Zero key, always ready: latency, done timing, known round keys
        tick();
        start_sched('0);
        @(negedge clk);
        check("latency_valid", rk_valid, 1);
        check("latency_round", rk_round, 0);
        wait_done(200, cyc);
        check("done_cycle_count", cyc, ROUNDS);
        for (int r = 0; r < 4; r++) check("zero_key_raw_seg", obs_rk[r], 0);
        check("zero_key_r4", obs_rk[4], 128'h1);
        check("zero_key_r5", obs_rk[5], 128'h2);
        check("zero_key_r8", obs_rk[8], 128'hD);
        // start during DONE must be ignored
        key_in = rand_key();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        @(negedge clk);
        check("done_start_ignored_valid", rk_valid, 0);
        check("done_start_ignored_state", dbg_state, IDLE);
        check("done_single_pulse", done, 0);
        check("done_count_1", done_seen, 1);

        // MSB-only key with random back-pressure and a start during RUN
        ready_rand = 1'b1;
        tick();
        k = '0;
        k[0] = 1'b1;
        start_sched(k);
        repeat (10) tick();
        key_in = rand_key();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(2000, cyc);
        top_bit = '0;
        top_bit[SIDE_SIZE-1] = 1'b1;
        check("msb_key_r0", obs_rk[0], top_bit);
        check("msb_key_r4", obs_rk[4], 128'h5);

        // start in the IDLE cycle right after DONE, then a 10-cycle stall at round 2
        ready_manual = 1'b1;
        ready_val    = 1'b1;
        tick();
        start_sched(rand_key());
        @(negedge clk);
        check("b2b_valid", rk_valid, 1);
        check("b2b_round0", rk_round, 0);
        @(negedge clk);
        check("pre_stall_round1", rk_round, 1);
        ready_val = 1'b0;
        hold_rk = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                hold_rk = rk;
                check("stall_rk_model", rk, exp_q[0]);
            end
            check("stall_round2", rk_round, 2);
            check("stall_valid", rk_valid, 1);
            check("stall_rk_const", rk, hold_rk);
        end
        ready_manual = 1'b0;
        ready_rand   = 1'b0;
        wait_done(2000, cyc);

        // Reset in the middle of a schedule, then restart with a new key
        ready_rand = 1'b1;
        tick();
        start_sched(rand_key());
        cyc = 0;
        @(negedge clk);
        while (!(rk_valid && rk_round == 30) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_round30", rk_round, 30);
        rst = 1'b1;
        tick();
        exp_q.delete();
        exp_round_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        tick();
        start_sched(rand_key());
        @(negedge clk);
        check("restart_valid", rk_valid, 1);
        check("restart_round0", rk_round, 0);
        wait_done(2000, cyc);

        // Random keys under random back-pressure
        for (int t = 0; t < 3; t++) begin
            tick();
            start_sched(rand_key());
            wait_done(2000, cyc);
        end

        tick();
        @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_count", done_seen, 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
